ins8070_bus_initiator: RTL

//  Bus-cycle initiator for the INS8070 external memory bus, clocked by sys_clk.

---
 rtl/ins8070_bus_initiator.sv | 114 +++++++++++
 1 files changed

// File: rtl/ins8070_bus_initiator.sv
// INS8070 external bus cycle initiator: turns a valid/ready request stream into
// timed A/NRDS/NWDS/D bus cycles with wait_n strobe extension.
module ins8070_bus_initiator #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned T_RECOV  = 1
) (
  input  logic        sys_clk,
  input  logic        RESET_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        wait_n,
  output logic [15:0] A,
  output logic        NRDS,
  output logic        NWDS,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LAST = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(T_HOLD - 1);
  localparam logic [7:0] RECOV_LAST  = 8'(T_RECOV - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       is_write;

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      is_write  <= 1'b0;
      A         <= 16'd0;
      NRDS      <= 1'b1;
      NWDS      <= 1'b1;
      D_out     <= 8'd0;
      D_oe      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            A         <= req_addr;
            D_out     <= req_wdata;
            D_oe      <= req_write;
            is_write  <= req_write;
            req_ready <= 1'b0;
            cnt       <= 8'd0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= 8'd0;
            state <= STROBE;
            if (is_write) NWDS <= 1'b0;
            else          NRDS <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // The counter parks on its last value while the responder holds wait_n low.
        STROBE: begin
          if (cnt == STROBE_LAST) begin
            if (wait_n) begin
              if (!is_write) rsp_rdata <= D_in;
              NRDS  <= 1'b1;
              NWDS  <= 1'b1;
              cnt   <= 8'd0;
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) rsp_valid <= 1'b1;
          if (cnt == HOLD_LAST) begin
            D_oe  <= 1'b0;
            cnt   <= 8'd0;
            state <= RECOV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RECOV: begin
          if (cnt == RECOV_LAST) begin
            cnt       <= 8'd0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
